// File: rtl/spi_slave_gen2_pkg.sv
// Shared types and command encodings for the parametrised SPI slave.
package spi_slave_gen2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    TX_WAIT,
    TX_SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-to-serial shifter for the read-data phase; bit order fixed by LSB_FIRST.
module spi_tx_serializer #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      if (LSB_FIRST) sreg <= {1'b0, sreg[DATA_W-1:1]};
      else           sreg <= {sreg[DATA_W-2:0], 1'b0};
      if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
    end
  end

  assign bit_out = LSB_FIRST ? sreg[0] : sreg[DATA_W-1];
  assign last    = (cnt == CNT_LAST);

endmodule

// File: rtl/spi_slave_gen2.sv
// SPI slave: receives {cmd, payload} frames, serves read data with handshake,
// timeout fallback, read-sequence checking and abort detection.
module spi_slave_gen2 #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              busy
);
  import spi_slave_gen2_pkg::*;

  localparam int BW = $clog2(DATA_W + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     to_cnt;
  logic [1:0]        cmd_sr;
  logic [DATA_W-1:0] pay_sr, pay_nxt;
  logic              rd_armed;

  logic              sample, frame_done, err_nxt, tx_load, ser_shift;
  logic              ser_bit, ser_last;
  logic [DATA_W-1:0] load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sample     = 1'b0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    tx_load    = 1'b0;
    ser_shift  = 1'b0;
    case (state)
      IDLE: if (!SS_n) state_nxt = RECV;
      RECV: begin
        if (SS_n) begin
          state_nxt = IDLE;
          err_nxt   = (bit_cnt != '0);
        end else begin
          sample = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            frame_done = 1'b1;
            state_nxt  = DONE;
            if (cmd_sr == CMD_RD_DATA) begin
              if (rd_armed) state_nxt = TX_WAIT;
              else          err_nxt   = 1'b1;
            end
          end
        end
      end
      TX_WAIT: begin
        if (SS_n) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (tx_valid) begin
          tx_load   = 1'b1;
          state_nxt = TX_SHIFT;
        end else if (to_cnt == TO_LAST) begin
          tx_load   = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (SS_n) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          ser_shift = 1'b1;
          if (ser_last) state_nxt = DONE;
        end
      end
      DONE:    if (SS_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state == TX_WAIT);
    busy     = (state != IDLE);
    MISO     = (state == TX_SHIFT) ? ser_bit : 1'b0;
  end

  always_comb begin
    if (LSB_FIRST) pay_nxt = {MOSI, pay_sr[DATA_W-1:1]};
    else           pay_nxt = {pay_sr[DATA_W-2:0], MOSI};
  end

  // Timeout fallback replies all-ones; a same-edge tx_valid takes precedence.
  assign load_data = tx_valid ? tx_data : '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      to_cnt    <= '0;
      cmd_sr    <= '0;
      pay_sr    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_armed  <= 1'b0;
    end else begin
      rx_valid  <= frame_done;
      frame_err <= err_nxt;

      if (sample) begin
        if (bit_cnt < BW'(2)) cmd_sr <= {cmd_sr[0], MOSI};
        else                  pay_sr <= pay_nxt;
      end
      if (sample && state_nxt == RECV) bit_cnt <= bit_cnt + 1'b1;
      else if (state_nxt != RECV)      bit_cnt <= '0;

      if (state == TX_WAIT && state_nxt == TX_WAIT) begin
        if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      if (frame_done) begin
        rx_data <= {cmd_sr, pay_nxt};
        if (cmd_sr == CMD_RD_ADDR)      rd_armed <= 1'b1;
        else if (cmd_sr == CMD_RD_DATA) rd_armed <= 1'b0;
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tx_load),
    .load_data(load_data),
    .shift    (ser_shift),
    .bit_out  (ser_bit),
    .last     (ser_last)
  );

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Directed bench for spi_slave_gen2: MSB-first instance plus an LSB-first twin on shared inputs.
module tb_spi_slave_gen2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       miso_m, rx_valid_m, tx_ready_m, frame_err_m, busy_m;
  logic [9:0] rx_data_m;
  logic       miso_l, rx_valid_l, tx_ready_l, frame_err_l, busy_l;
  logic [9:0] rx_data_l;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_slave_gen2 #(.DATA_W(8), .LSB_FIRST(1'b0), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_m),
    .rx_data(rx_data_m), .rx_valid(rx_valid_m), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready_m), .frame_err(frame_err_m),
    .busy(busy_m)
  );

  spi_slave_gen2 #(.DATA_W(8), .LSB_FIRST(1'b1), .TIMEOUT(15)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_l),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready_l), .frame_err(frame_err_l),
    .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lowers SS_n, waits the select edge, then clocks 10 bits (bits[9] first).
  task automatic frame(input logic [9:0] bits);
    ss_n = 1'b0;
    @(negedge clk);
    for (int i = 9; i >= 0; i--) begin
      mosi = bits[i];
      @(negedge clk);
      if (i == 1) chk("rx_valid_early", {31'd0, rx_valid_m}, 32'd0);
    end
    mosi = 1'b0;
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    @(negedge clk);
  endtask

  // Checks DATA_W MISO bits on both instances; first call is right after the handshake edge.
  task automatic shift_check(input string tag, input logic [7:0] data, input logic err_first);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_miso_m"}, {31'd0, miso_m}, {31'd0, data[7-i]});
      chk({tag, "_miso_l"}, {31'd0, miso_l}, {31'd0, data[i]});
      if (i == 0) begin
        chk({tag, "_err0"}, {31'd0, frame_err_m}, {31'd0, err_first});
        chk({tag, "_rdy0"}, {31'd0, tx_ready_m}, 32'd0);
      end else begin
        chk({tag, "_err"}, {31'd0, frame_err_m}, 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, "_miso_end_m"}, {31'd0, miso_m}, 32'd0);
    chk({tag, "_miso_end_l"}, {31'd0, miso_l}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy_m}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_miso", {31'd0, miso_m}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid_m}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready_m}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err_m}, 32'd0);
    chk("rst_busy", {31'd0, busy_m}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data_m}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write address
    frame(10'b00_01010000);
    chk("wa_rx_data", {22'd0, rx_data_m}, 32'h050);
    chk("wa_rx_valid", {31'd0, rx_valid_m}, 32'd1);
    chk("wa_err", {31'd0, frame_err_m}, 32'd0);
    chk("wa_rx_data_lsb", {22'd0, rx_data_l}, 32'h00A);
    end_frame();
    chk("wa_rx_valid_drop", {31'd0, rx_valid_m}, 32'd0);
    chk("wa_busy_idle", {31'd0, busy_m}, 32'd0);

    // 2: write data
    frame(10'b01_10010000);
    chk("wd_rx_data", {22'd0, rx_data_m}, 32'h190);
    chk("wd_rx_valid", {31'd0, rx_valid_m}, 32'd1);
    chk("wd_miso", {31'd0, miso_m}, 32'd0);
    end_frame();

    // 3: legal read, handshake on first TX_WAIT cycle
    frame(10'b10_01010000);
    chk("ra_rx_data", {22'd0, rx_data_m}, 32'h250);
    chk("ra_rx_data_lsb", {22'd0, rx_data_l}, 32'h20A);
    chk("ra_tx_ready", {31'd0, tx_ready_m}, 32'd0);
    end_frame();
    frame(10'b11_11111111);
    chk("rd_rx_data", {22'd0, rx_data_m}, 32'h3FF);
    chk("rd_tx_ready", {31'd0, tx_ready_m}, 32'd1);
    chk("rd_tx_ready_lsb", {31'd0, tx_ready_l}, 32'd1);
    chk("rd_rx_valid_lsb", {31'd0, rx_valid_l}, 32'd1);
    chk("rd_err", {31'd0, frame_err_m}, 32'd0);
    tx_valid = 1'b1; tx_data = 8'h90;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    shift_check("rd90", 8'h90, 1'b0);
    end_frame();

    // 4: illegal read (rd_armed clear after reset)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(10'b11_10101010);
    chk("il_rx_valid", {31'd0, rx_valid_m}, 32'd1);
    chk("il_err", {31'd0, frame_err_m}, 32'd1);
    chk("il_rx_data", {22'd0, rx_data_m}, 32'h3AA);
    chk("il_tx_ready", {31'd0, tx_ready_m}, 32'd0);
    @(negedge clk);
    chk("il_err_drop", {31'd0, frame_err_m}, 32'd0);
    chk("il_tx_ready2", {31'd0, tx_ready_m}, 32'd0);
    end_frame();

    // 5a: timeout with tx_valid held low
    frame(10'b10_00000001);
    end_frame();
    frame(10'b11_00000000);
    for (int c = 1; c < 15; c++) begin
      chk("to_wait_ready", {31'd0, tx_ready_m}, 32'd1);
      chk("to_wait_err", {31'd0, frame_err_m}, 32'd0);
      @(negedge clk);
    end
    chk("to_c15_ready", {31'd0, tx_ready_m}, 32'd1);
    @(negedge clk);
    chk("to_err_lsb", {31'd0, frame_err_l}, 32'd1);
    shift_check("to_ff", 8'hFF, 1'b1);
    end_frame();

    // 5b: tx_valid exactly on cycle 15 beats the timeout
    frame(10'b10_00000010);
    end_frame();
    frame(10'b11_00000000);
    for (int c = 1; c < 15; c++) @(negedge clk);
    chk("tv15_ready", {31'd0, tx_ready_m}, 32'd1);
    tx_valid = 1'b1; tx_data = 8'hC5;
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00;
    shift_check("tv15", 8'hC5, 1'b0);
    end_frame();

    // 6: abort after 5 bits, then a clean frame
    ss_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      @(negedge clk);
    end
    ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    chk("ab_rx_valid", {31'd0, rx_valid_m}, 32'd0);
    chk("ab_err", {31'd0, frame_err_m}, 32'd1);
    chk("ab_busy", {31'd0, busy_m}, 32'd0);
    @(negedge clk);
    chk("ab_err_drop", {31'd0, frame_err_m}, 32'd0);
    frame(10'b00_00000011);
    chk("ab_next_rx_data", {22'd0, rx_data_m}, 32'h003);
    chk("ab_next_rx_data_lsb", {22'd0, rx_data_l}, 32'h0C0);
    end_frame();

    // abort before any bit sampled: no error
    ss_n = 1'b0;
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    chk("ab0_err", {31'd0, frame_err_m}, 32'd0);
    chk("ab0_busy", {31'd0, busy_m}, 32'd0);

    // reset asserted mid TX_SHIFT
    frame(10'b10_00000100);
    end_frame();
    frame(10'b11_00000000);
    tx_valid = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("mr_miso_before", {31'd0, miso_m}, 32'd1);
    #2 rst_n = 1'b0; ss_n = 1'b1;
    #1;
    chk("mr_miso", {31'd0, miso_m}, 32'd0);
    chk("mr_busy", {31'd0, busy_m}, 32'd0);
    chk("mr_busy_lsb", {31'd0, busy_l}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // rd_armed must have been cleared by reset
    frame(10'b11_00000000);
    chk("mr_rd_unarmed_err", {31'd0, frame_err_m}, 32'd1);
    chk("mr_rd_unarmed_ready", {31'd0, tx_ready_m}, 32'd0);
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
